// File: rtl/vx_lru_req_sched.sv
// vx_lru_req_sched: round-robin scheduler that lets NUM_REQS clients share one
// LRU victim queue (push / pop / touch / flush). One queue strobe per cycle;
// pop data returns to the winning client over a valid/ready response channel.
module vx_lru_req_sched #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 32,
  parameter int REQ_SELW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset,       // asynchronous, active-low
  input  logic [NUM_REQS-1:0]       i_req_valid,
  input  logic [NUM_REQS*2-1:0]     i_req_op,
  input  logic [NUM_REQS*DATAW-1:0] i_req_data,
  output logic [NUM_REQS-1:0]       o_req_ready,
  output logic                      o_rsp_valid,
  output logic [REQ_SELW-1:0]       o_rsp_idx,
  output logic [DATAW-1:0]          o_rsp_data,
  input  logic                      i_rsp_ready,
  output logic                      o_q_push,
  output logic                      o_q_pop,
  output logic                      o_q_touch,
  output logic [DATAW-1:0]          o_q_data_in,
  input  logic [DATAW-1:0]          i_q_data_out,
  input  logic                      i_q_empty,
  input  logic                      i_q_full,
  output logic                      o_busy
);

  typedef enum logic [1:0] {
    OP_PUSH  = 2'b00,
    OP_POP   = 2'b01,
    OP_TOUCH = 2'b10,
    OP_FLUSH = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RSP   = 2'b01,
    ST_FLUSH = 2'b10
  } state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [REQ_SELW-1:0]   r_rr;
  logic                  r_rsp_valid;
  logic [REQ_SELW-1:0]   r_rsp_idx;
  logic [DATAW-1:0]      r_rsp_data;

  logic [1:0]            w_op   [NUM_REQS];
  logic [DATAW-1:0]      w_data [NUM_REQS];
  logic [NUM_REQS-1:0]   w_elig;
  logic                  w_found;
  logic [REQ_SELW-1:0]   w_winner;
  logic [REQ_SELW-1:0]   w_cand;
  op_e                   w_win_op;
  logic                  w_grant;

  // Unpack per-requester fields and decide who could be served by the queue right now
  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      w_op[i]   = i_req_op[2*i +: 2];
      w_data[i] = i_req_data[DATAW*i +: DATAW];
      case (op_e'(w_op[i]))
        OP_PUSH:  w_elig[i] = i_req_valid[i] & ~i_q_full;
        OP_FLUSH: w_elig[i] = i_req_valid[i];
        default:  w_elig[i] = i_req_valid[i] & ~i_q_empty;
      endcase
    end
  end

  // Round-robin search over eligible requesters, starting just after the last winner
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int k = 1; k <= NUM_REQS; k++) begin
      w_cand = REQ_SELW'((int'(r_rr) + k) % NUM_REQS);
      if (!w_found && w_elig[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  assign w_win_op = op_e'(w_op[w_winner]);
  assign w_grant  = i_reset && (r_state == ST_IDLE) && w_found;

  // Next-state logic plus grant and queue strobes; everything forced quiet while in reset
  always_comb begin
    w_state_nxt = r_state;
    o_req_ready = '0;
    o_q_push    = 1'b0;
    o_q_pop     = 1'b0;
    o_q_touch   = 1'b0;
    o_q_data_in = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          o_req_ready[w_winner] = 1'b1;
          case (w_win_op)
            OP_PUSH: begin
              o_q_push    = 1'b1;
              o_q_data_in = w_data[w_winner];
            end
            OP_TOUCH: begin
              o_q_touch   = 1'b1;
              o_q_data_in = w_data[w_winner];
            end
            OP_POP: begin
              o_q_pop     = 1'b1;
              w_state_nxt = ST_RSP;
            end
            default: begin
              if (!i_q_empty) begin
                o_q_pop     = 1'b1;
                w_state_nxt = ST_FLUSH;
              end
            end
          endcase
        end
      end
      ST_RSP: begin
        if (r_rsp_valid && i_rsp_ready) w_state_nxt = ST_IDLE;
      end
      ST_FLUSH: begin
        if (!i_q_empty) o_q_pop = 1'b1;
        else            w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (!i_reset) begin
      o_req_ready = '0;
      o_q_push    = 1'b0;
      o_q_pop     = 1'b0;
      o_q_touch   = 1'b0;
      o_q_data_in = '0;
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Round-robin pointer only moves when a grant is actually issued
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)     r_rr <= '0;
    else if (w_grant) r_rr <= w_winner;
  end

  // Response register: captured on a pop grant, held until the client accepts it
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_idx   <= '0;
      r_rsp_data  <= '0;
    end else if (w_grant && (w_win_op == OP_POP)) begin
      r_rsp_valid <= 1'b1;
      r_rsp_idx   <= w_winner;
      r_rsp_data  <= i_q_data_out;
    end else if ((r_state == ST_RSP) && r_rsp_valid && i_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_idx   = r_rsp_idx;
  assign o_rsp_data  = r_rsp_data;
  assign o_busy      = (r_state != ST_IDLE);

endmodule
